// File: rtl/register_file_pkg.sv
// Shared defaults and types for the reservation register file.
// Optional same-cycle store forwarding is enabled by REGFILE_STORE_BYPASS_EN.
package register_file_pkg;
  localparam int DATA_WIDTH_DEF  = 32;
  localparam int INDEX_WIDTH_DEF = 5;
  localparam int LOAD_PORTS_DEF  = 4;
  localparam int STORE_PORTS_DEF = 2;

  typedef logic [INDEX_WIDTH_DEF-1:0] index_t;
  typedef logic [DATA_WIDTH_DEF-1:0]  word_t;

  localparam word_t RESET_WORD = '0;
endpackage

// File: rtl/reservation_scoreboard.sv
// Pending-bit scoreboard: reserve/store priority and operand validity check.
// REGFILE_STORE_BYPASS_EN lets a same-cycle committed store validate an operand.
module reservation_scoreboard
  import register_file_pkg::*;
#(
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int LOAD_PORTS  = LOAD_PORTS_DEF,
  parameter int STORE_PORTS = STORE_PORTS_DEF
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [STORE_PORTS-1:0][INDEX_WIDTH-1:0] reserve_idx,
  input  logic [STORE_PORTS-1:0]                  reserve_en,
  input  logic [STORE_PORTS-1:0][INDEX_WIDTH-1:0] store_idx,
  input  logic [STORE_PORTS-1:0]                  store_commit,
  input  logic [LOAD_PORTS-1:0][INDEX_WIDTH-1:0]  load_idx,
  output logic                                    all_valid,
  output logic [(2**INDEX_WIDTH)-1:0]             pending
);
  localparam int DEPTH = 2**INDEX_WIDTH;

  logic [DEPTH-1:0]      pending_nxt;
  logic [LOAD_PORTS-1:0] valid;

  // Reserves are applied after clears so a new producer supersedes a retiring one.
  always_comb begin
    pending_nxt = pending;
    for (int p = 0; p < STORE_PORTS; p++)
      if (store_commit[p]) pending_nxt[store_idx[p]] = 1'b0;
    for (int p = 0; p < STORE_PORTS; p++)
      if (reserve_en[p]) pending_nxt[reserve_idx[p]] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_comb begin
    valid = '0;
    for (int i = 0; i < LOAD_PORTS; i++) begin
      valid[i] = (load_idx[i] == '0) || !pending[load_idx[i]];
`ifdef REGFILE_STORE_BYPASS_EN
      for (int p = 0; p < STORE_PORTS; p++)
        if (store_commit[p] && store_idx[p] == load_idx[i]) valid[i] = 1'b1;
`endif
    end
    all_valid = &valid;
  end
endmodule

// File: rtl/reservation_register_file.sv
// Multi-port register file with reservation scoreboard and registered operand fetch.
// Define REGFILE_STORE_BYPASS_EN to forward same-cycle committed stores to load ports.
module reservation_register_file
  import register_file_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int INDEX_WIDTH = INDEX_WIDTH_DEF,
  parameter int LOAD_PORTS  = LOAD_PORTS_DEF,
  parameter int STORE_PORTS = STORE_PORTS_DEF
) (
  input  logic                                    clockIn,
  input  logic                                    resetIn,
  input  logic [LOAD_PORTS-1:0][INDEX_WIDTH-1:0]  loadIndicesIn,
  input  logic                                    loadLatchIn,
  output logic [LOAD_PORTS-1:0][DATA_WIDTH-1:0]   loadValuesOut,
  output logic                                    readyOut,
  input  logic [STORE_PORTS-1:0][INDEX_WIDTH-1:0] reserveIndicesIn,
  input  logic [STORE_PORTS-1:0]                  reserveEnableIn,
  input  logic [STORE_PORTS-1:0][INDEX_WIDTH-1:0] storeIndicesIn,
  input  logic [STORE_PORTS-1:0][DATA_WIDTH-1:0]  storeValuesIn,
  input  logic [STORE_PORTS-1:0]                  storeEnableIn,
  input  logic                                    storeLatchIn,
  output logic [(2**INDEX_WIDTH)-1:0]             pendingOut
);
  localparam int DEPTH = 2**INDEX_WIDTH;
  localparam logic [DATA_WIDTH-1:0] RST_VAL = DATA_WIDTH'(RESET_WORD);

  logic [DEPTH-1:0][DATA_WIDTH-1:0]      regs;
  logic [STORE_PORTS-1:0]                store_commit;
  logic [LOAD_PORTS-1:0][DATA_WIDTH-1:0] load_data;
  logic                                  all_valid;

  assign store_commit = {STORE_PORTS{storeLatchIn}} & storeEnableIn;

  // Later loop iterations override earlier ones: highest-numbered port wins.
  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      regs <= {DEPTH{RST_VAL}};
    end else begin
      for (int p = 0; p < STORE_PORTS; p++)
        if (store_commit[p] && storeIndicesIn[p] != '0)
          regs[storeIndicesIn[p]] <= storeValuesIn[p];
    end
  end

  always_comb begin
    load_data = '0;
    for (int i = 0; i < LOAD_PORTS; i++) begin
      if (loadIndicesIn[i] != '0) load_data[i] = regs[loadIndicesIn[i]];
`ifdef REGFILE_STORE_BYPASS_EN
      for (int p = 0; p < STORE_PORTS; p++)
        if (store_commit[p] && loadIndicesIn[i] != '0 && storeIndicesIn[p] == loadIndicesIn[i])
          load_data[i] = storeValuesIn[p];
`endif
    end
  end

  always_ff @(posedge clockIn) begin
    if (resetIn) begin
      loadValuesOut <= '0;
      readyOut      <= 1'b0;
    end else if (loadLatchIn) begin
      loadValuesOut <= load_data;
      readyOut      <= all_valid;
    end
  end

  reservation_scoreboard #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .LOAD_PORTS  (LOAD_PORTS),
    .STORE_PORTS (STORE_PORTS)
  ) u_scoreboard (
    .clk          (clockIn),
    .rst          (resetIn),
    .reserve_idx  (reserveIndicesIn),
    .reserve_en   (reserveEnableIn),
    .store_idx    (storeIndicesIn),
    .store_commit (store_commit),
    .load_idx     (loadIndicesIn),
    .all_valid    (all_valid),
    .pending      (pendingOut)
  );
endmodule

// File: tb/tb_reservation_register_file.sv
// Directed bench for reservation_register_file; bypass expectations follow REGFILE_STORE_BYPASS_EN.
module tb_reservation_register_file;
  localparam int DW = 32, IW = 5, LP = 4, SP = 2;

  logic                   clockIn = 1'b0;
  logic                   resetIn;
  logic [LP-1:0][IW-1:0]  loadIndicesIn;
  logic                   loadLatchIn;
  logic [LP-1:0][DW-1:0]  loadValuesOut;
  logic                   readyOut;
  logic [SP-1:0][IW-1:0]  reserveIndicesIn;
  logic [SP-1:0]          reserveEnableIn;
  logic [SP-1:0][IW-1:0]  storeIndicesIn;
  logic [SP-1:0][DW-1:0]  storeValuesIn;
  logic [SP-1:0]          storeEnableIn;
  logic                   storeLatchIn;
  logic [(2**IW)-1:0]     pendingOut;

  int checks = 0;
  int fails  = 0;

  reservation_register_file #(
    .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .LOAD_PORTS(LP), .STORE_PORTS(SP)
  ) dut (
    .clockIn(clockIn), .resetIn(resetIn),
    .loadIndicesIn(loadIndicesIn), .loadLatchIn(loadLatchIn),
    .loadValuesOut(loadValuesOut), .readyOut(readyOut),
    .reserveIndicesIn(reserveIndicesIn), .reserveEnableIn(reserveEnableIn),
    .storeIndicesIn(storeIndicesIn), .storeValuesIn(storeValuesIn),
    .storeEnableIn(storeEnableIn), .storeLatchIn(storeLatchIn),
    .pendingOut(pendingOut)
  );

  always #5 clockIn = ~clockIn;

  task automatic idle();
    resetIn = 0; loadIndicesIn = '0; loadLatchIn = 0;
    reserveIndicesIn = '0; reserveEnableIn = '0;
    storeIndicesIn = '0; storeValuesIn = '0; storeEnableIn = '0; storeLatchIn = 0;
  endtask

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clockIn); #1;
  endtask

  task automatic latch_all(input logic [IW-1:0] idx);
    idle(); loadLatchIn = 1;
    for (int i = 0; i < LP; i++) loadIndicesIn[i] = idx;
  endtask

  task automatic test_reset();
    idle(); resetIn = 1; tick(); tick();
    checks++; if (loadValuesOut !== '0) begin fails++; $display("FAIL reset_values got %h want 0", loadValuesOut); end
    checks++; if (pendingOut !== '0) begin fails++; $display("FAIL reset_pending got %h want 0", pendingOut); end
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", readyOut); end
    idle();
    storeLatchIn = 1; storeEnableIn = 2'b01; storeIndicesIn[0] = 5; storeValuesIn[0] = 32'h1234;
    reserveEnableIn = 2'b01; reserveIndicesIn[0] = 7;
    tick();
    checks++; if (pendingOut !== 32'h0000_0080) begin fails++; $display("FAIL pre_reset_pending got %h want 00000080", pendingOut); end
    latch_all(5); tick();
    checks++; if (loadValuesOut[0] !== 32'h1234) begin fails++; $display("FAIL pre_reset_r5 got %h want 1234", loadValuesOut[0]); end
    // Reset cycle with a store, reserve and load that must all be ignored.
    latch_all(5); resetIn = 1;
    storeLatchIn = 1; storeEnableIn = 2'b01; storeIndicesIn[0] = 8; storeValuesIn[0] = 32'h55;
    reserveEnableIn = 2'b01; reserveIndicesIn[0] = 8;
    tick();
    checks++; if (loadValuesOut !== '0) begin fails++; $display("FAIL mid_reset_values got %h want 0", loadValuesOut); end
    checks++; if (pendingOut !== '0) begin fails++; $display("FAIL mid_reset_pending got %h want 0", pendingOut); end
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL mid_reset_ready got %b want 0", readyOut); end
    latch_all(5); loadIndicesIn[1] = 8; tick();
    checks++; if (loadValuesOut[0] !== '0 || loadValuesOut[1] !== '0) begin fails++; $display("FAIL post_reset_r5 got %h want 0", loadValuesOut); end
    checks++; if (readyOut !== 1'b1) begin fails++; $display("FAIL post_reset_ready got %b want 1", readyOut); end
  endtask

  task automatic test_reserve_store();
    idle(); reserveEnableIn = 2'b10; reserveIndicesIn[1] = 3; tick();
    checks++; if (pendingOut[3] !== 1'b1) begin fails++; $display("FAIL rs_pending_set got %b want 1", pendingOut[3]); end
    latch_all(3); tick();
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL rs_ready_pending got %b want 0", readyOut); end
    idle(); storeLatchIn = 1; storeEnableIn = 2'b10; storeIndicesIn[1] = 3; storeValuesIn[1] = 32'hDEAD; tick();
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL rs_hold_ready got %b want 0", readyOut); end
    checks++; if (pendingOut[3] !== 1'b0) begin fails++; $display("FAIL rs_pending_clr got %b want 0", pendingOut[3]); end
    latch_all(3); tick();
    checks++; if (loadValuesOut[2] !== 32'hDEAD) begin fails++; $display("FAIL rs_value got %h want dead", loadValuesOut[2]); end
    checks++; if (readyOut !== 1'b1) begin fails++; $display("FAIL rs_ready got %b want 1", readyOut); end
  endtask

  task automatic test_same_cycle();
    idle(); reserveEnableIn = 2'b01; reserveIndicesIn[0] = 4;
    storeLatchIn = 1; storeEnableIn = 2'b10; storeIndicesIn[1] = 4; storeValuesIn[1] = 32'h4444;
    tick();
    checks++; if (pendingOut[4] !== 1'b1) begin fails++; $display("FAIL same_pending got %b want 1", pendingOut[4]); end
    latch_all(4); tick();
    checks++; if (loadValuesOut[3] !== 32'h4444) begin fails++; $display("FAIL same_value got %h want 4444", loadValuesOut[3]); end
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL same_ready got %b want 0", readyOut); end
    // Store without latch leaves pending clear for later tests.
    idle(); storeEnableIn = 2'b01; storeIndicesIn[0] = 4; tick();
    checks++; if (pendingOut[4] !== 1'b1) begin fails++; $display("FAIL unlatched_store got %b want 1", pendingOut[4]); end
    storeLatchIn = 1; storeValuesIn[0] = 32'h4445; tick();
    checks++; if (pendingOut[4] !== 1'b0) begin fails++; $display("FAIL same_clear got %b want 0", pendingOut[4]); end
  endtask

  task automatic test_collision();
    idle(); storeLatchIn = 1; storeEnableIn = 2'b11;
    storeIndicesIn[0] = 9; storeValuesIn[0] = 32'h1;
    storeIndicesIn[1] = 9; storeValuesIn[1] = 32'h2;
    tick();
    latch_all(9); tick();
    checks++; if (loadValuesOut[1] !== 32'h2) begin fails++; $display("FAIL collision got %h want 2", loadValuesOut[1]); end
  endtask

  task automatic test_reg0();
    idle(); storeLatchIn = 1; storeEnableIn = 2'b01; storeIndicesIn[0] = 0; storeValuesIn[0] = 32'hFFFF;
    reserveEnableIn = 2'b10; reserveIndicesIn[1] = 0; tick();
    checks++; if (pendingOut[0] !== 1'b0) begin fails++; $display("FAIL r0_pending got %b want 0", pendingOut[0]); end
    latch_all(0); tick();
    checks++; if (loadValuesOut !== '0) begin fails++; $display("FAIL r0_value got %h want 0", loadValuesOut); end
    checks++; if (readyOut !== 1'b1) begin fails++; $display("FAIL r0_ready got %b want 1", readyOut); end
  endtask

  task automatic test_mixed_ports();
    // r3=dead, r9=2, r4=4445, r0=0, all not pending.
    idle(); loadLatchIn = 1;
    loadIndicesIn[0] = 3; loadIndicesIn[1] = 9; loadIndicesIn[2] = 4; loadIndicesIn[3] = 0;
    tick();
    checks++; if (loadValuesOut !== {32'h0, 32'h4445, 32'h2, 32'hDEAD}) begin fails++; $display("FAIL mixed_values got %h", loadValuesOut); end
    checks++; if (readyOut !== 1'b1) begin fails++; $display("FAIL mixed_ready got %b want 1", readyOut); end
    // Hold: indices change with latch low.
    idle(); loadIndicesIn[0] = 9; tick();
    checks++; if (loadValuesOut[0] !== 32'hDEAD || readyOut !== 1'b1) begin fails++; $display("FAIL hold got %h/%b want dead/1", loadValuesOut[0], readyOut); end
  endtask

  task automatic test_bypass();
    idle(); storeLatchIn = 1; storeEnableIn = 2'b01; storeIndicesIn[0] = 6; storeValuesIn[0] = 32'h1111;
    reserveEnableIn = 2'b10; reserveIndicesIn[1] = 6; tick();
    latch_all(6); loadIndicesIn[3] = 3;
    storeLatchIn = 1; storeEnableIn = 2'b10; storeIndicesIn[1] = 6; storeValuesIn[1] = 32'hBEEF;
    tick();
`ifdef REGFILE_STORE_BYPASS_EN
    checks++; if (loadValuesOut[0] !== 32'hBEEF) begin fails++; $display("FAIL bypass_value got %h want beef", loadValuesOut[0]); end
    checks++; if (readyOut !== 1'b1) begin fails++; $display("FAIL bypass_ready got %b want 1", readyOut); end
`else
    checks++; if (loadValuesOut[0] !== 32'h1111) begin fails++; $display("FAIL bypass_value got %h want 1111", loadValuesOut[0]); end
    checks++; if (readyOut !== 1'b0) begin fails++; $display("FAIL bypass_ready got %b want 0", readyOut); end
`endif
    checks++; if (loadValuesOut[3] !== 32'hDEAD) begin fails++; $display("FAIL bypass_other got %h want dead", loadValuesOut[3]); end
    latch_all(6); tick();
    checks++; if (loadValuesOut[2] !== 32'hBEEF || readyOut !== 1'b1) begin fails++; $display("FAIL bypass_retry got %h/%b want beef/1", loadValuesOut[2], readyOut); end
  endtask

  initial begin
    idle();
    test_reset();
    test_reserve_store();
    test_same_cycle();
    test_collision();
    test_reg0();
    test_mixed_ports();
    test_bypass();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule

// File: doc/reservation_register_file.md
# reservation_register_file

Parametrised multi-port register file with a per-register reservation scoreboard, the successor to the fixed 4-read/2-write register file in the issue stage. Issue logic reserves destination registers, writeback stores results and clears reservations, and operand fetch latches register values with a `readyOut` flag. `readyOut` reports whether every fetched operand was valid. Register 0 always reads zero and can never be reserved.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register width in bits
- `INDEX_WIDTH`, 5, index width; depth = 2**INDEX_WIDTH
- `LOAD_PORTS`, 4, number of read ports
- `STORE_PORTS`, 2, number of write ports and reserve ports

Ports:
- `clockIn`  input  1  sole clock, rising edge
- `resetIn`  input  1  synchronous, active-high reset
- `loadIndicesIn`  input  [INDEX_WIDTH-1:0] x LOAD_PORTS  read indices
- `loadLatchIn`  input  1  capture all read ports this cycle
- `loadValuesOut`  output  [DATA_WIDTH-1:0] x LOAD_PORTS  registered read data
- `readyOut`  output  1  registered; all operands of the last latch were valid
- `reserveIndicesIn`  input  [INDEX_WIDTH-1:0] x STORE_PORTS  indices to mark pending
- `reserveEnableIn`  input  STORE_PORTS  per-port reserve enable
- `storeIndicesIn`  input  [INDEX_WIDTH-1:0] x STORE_PORTS  write indices
- `storeValuesIn`  input  [DATA_WIDTH-1:0] x STORE_PORTS  write data
- `storeEnableIn`  input  STORE_PORTS  per-port write enable, qualified by `storeLatchIn`
- `storeLatchIn`  input  1  commit enabled store ports this cycle
- `pendingOut`  output  2**INDEX_WIDTH  current reservation bits, registered

## Operation
- State consists of the register array and one pending bit per register.
- **Store:** port p writes in cycle N when `storeLatchIn && storeEnableIn[p]`.
  - Writes to index 0 are discarded.
  - If two ports hit the same index, the higher-numbered port wins.
  - A store clears that index's pending bit at the end of cycle N.
- **Reserve:** port p sets the pending bit of its index when `reserveEnableIn[p]`. Index 0 is ignored.
- **Reserve and store on the same index, same cycle:** the reserve wins, so the bit stays set (a new producer supersedes the retiring one). The store data is still written.
- **Load:** when `loadLatchIn` is high in cycle N, each `loadValuesOut[i]` captures the register value at the start of cycle N. Index 0 returns 0.
- **Operand validity:** operand i is valid if any of the following holds:
  - its index is 0;
  - its pending bit was clear at the start of cycle N;
  - (with bypass only) an enabled store to that index commits in cycle N.
- **readyOut:** at N+1 equals the AND of all LOAD_PORTS validity terms.
- **Hold:** when `loadLatchIn` is low, `loadValuesOut` and `readyOut` hold.
- A not-ready consumer re-asserts `loadLatchIn` on a later cycle. No internal retry.

## Timing
- **Reset** (`resetIn` high at an edge):
  - all registers, pending bits, `loadValuesOut` and `pendingOut` become 0;
  - `readyOut` becomes 0;
  - stores, reserves and loads in that cycle are ignored.
- **Reset mid-operation:** all outstanding reservations are dropped.
- **Load latency:** one cycle from `loadLatchIn` to `loadValuesOut`/`readyOut`.
- **Store visibility:**
  - a store in cycle N is visible to a plain load latched in cycle N+1;
  - it is visible to a load in cycle N only with bypass.
- **Reserve visibility:** a reserve in cycle N affects validity of loads latched in cycle N+1 onward, not in cycle N.
- **pendingOut:** reflects updates one cycle after the reserve or store.
- Every output is a flop; there are no combinational input-to-output paths.

## Configuration
- `REGFILE_STORE_BYPASS_EN` defined: a same-cycle committed store is forwarded to matching load ports.
  - The highest-numbered matching store port wins.
  - The forwarded operand counts as valid.
- Not defined: loads read the pre-store array. A register whose pending bit is cleared by a same-cycle store is still reported not ready.

## Structure
- Package `register_file_pkg` holds:
  - default parameter constants;
  - `index_t` and `word_t` typedefs;
  - the reset value constant.
- Sub-module `reservation_scoreboard` holds pending-bit storage, the reserve/store priority, the validity check and `pendingOut`. The data array and load/bypass muxing stay in the top.

## Test plan
- **Reset:** write r5=0x1234, reserve r7, pulse `resetIn` → all `loadValuesOut`=0, `pendingOut`=0, `readyOut`=0; a load of r5 at N+1 returns 0 with `readyOut`=1.
- **Reserve then store:** reserve r3; latch r3 → `readyOut`=0. Store r3=0xDEAD, latch next cycle → value 0xDEAD, `readyOut`=1.
- **Same-cycle reserve and store on r4:** `pendingOut[4]` stays 1 and the array holds the new value.
- **Dual store collision:** ports 0 and 1 write r9 with 0x1 and 0x2 → r9 reads 0x2.
- **Register 0:** store 0xFFFF and reserve r0 → reads 0, `readyOut`=1, `pendingOut[0]`=0.
- **Bypass:** r6 pending, store r6=0xBEEF and latch r6 in the same cycle.
  - With `REGFILE_STORE_BYPASS_EN`: 0xBEEF with `readyOut`=1.
  - Without it: old value with `readyOut`=0.
